txdatfifo: RTL and testbench
============================

// Module: txdatfifo
//
// PURPOSE
//  Parametrised successor of the single-byte Tx data register: a first-word-fall-through
//  FIFO between the APB-side bus write path and the USRT transmitter. Bus writes push
//  words; the transmitter pops the head word by pulsing i_Done after shifting it out.
//  Adds depth, full/empty/level flags, write-error reporting and a sticky overflow flag.
//
// PARAMETERS
//  WIDTH     8   data word width in bits (>=1)
//  DEPTH     4   FIFO depth in words; power of two, >=2
//  LOW_MARK  1   o_Low asserted while occupancy <= LOW_MARK (0..DEPTH-1)
//
// PORTS
//  i_Pclk      in   1                 bus/system clock; all logic on rising edge
//  i_Reset     in   1                 synchronous reset, active-high
//  i_Enable    in   1                 write request; each cycle high = one push request
//  i_Data      in   WIDTH             write data, sampled when i_Enable=1
//  i_Done      in   1                 transmitter finished head word; pop request
//  i_ClrOvf    in   1                 clears o_Overflow
//  o_Data      out  WIDTH             head word (valid while o_Busy=1)
//  o_Busy      out  1                 FIFO non-empty: transmitter has data to send
//  o_Pready    out  1                 1-cycle completion pulse for a write request
//  o_Perr      out  1                 qualifies o_Pready: write was rejected (FIFO full)
//  o_Full      out  1                 occupancy == DEPTH
//  o_Low       out  1                 occupancy <= LOW_MARK (refill request)
//  o_Count     out  $clog2(DEPTH+1)   current occupancy, 0..DEPTH
//  o_Overflow  out  1                 sticky: a write was rejected since last clear
//
// BEHAVIOUR
//  - Reset (i_Reset=1 at edge): pointers/count=0, o_Busy=0, o_Full=0, o_Low=1,
//    o_Pready=0, o_Perr=0, o_Overflow=0, o_Count=0; o_Data=0. Reset overrides all inputs,
//    including mid-transfer; stored words discarded, no Pready issued for that cycle.
//  - Storage: DEPTH x WIDTH register array, write ptr/read ptr of $clog2(DEPTH) bits,
//    wrap naturally modulo DEPTH; occupancy tracked in separate counter.
//  - Push: at edge with i_Enable=1: accepted if count<DEPTH, or count==DEPTH and
//    i_Done=1 in the same cycle (pop frees the slot). Accepted word written at wptr, wptr++.
//  - Rejected push: data dropped, o_Overflow set (sticky), o_Perr=1 with the Pready pulse.
//  - o_Pready: registered; high exactly one cycle after each cycle of i_Enable=1;
//    o_Perr valid only while o_Pready=1, else 0. Back-to-back enables -> back-to-back pulses.
//  - Pop: at edge with i_Done=1 and count>0: rptr++. i_Done with count==0 ignored
//    (no underflow, count stays 0), including when a push occurs same cycle.
//  - Simultaneous push+pop with 0<count<DEPTH: count unchanged, both pointers advance.
//  - FWFT: o_Data = mem[rptr]; a word pushed into an empty FIFO appears on o_Data and
//    o_Busy rises one cycle after the i_Enable cycle (same edge as o_Pready).
//  - Flags all derived from registered count: o_Busy=(count!=0), o_Full=(count==DEPTH),
//    o_Low=(count<=LOW_MARK); no combinational path from inputs to any output.
//  - o_Overflow: cleared by i_ClrOvf; if rejection and i_ClrOvf in same cycle, set wins.
//
// TESTING (WIDTH=8, DEPTH=4, LOW_MARK=1)
//  1 Reset, then push 8'h53 -> next cycle o_Pready=1, o_Perr=0, o_Busy=1, o_Data=8'h53,
//    o_Count=1, o_Low=1; Pready low again the cycle after.
//  2 Push 8'h01,8'h02,8'h03,8'h04 back-to-back -> o_Full=1, o_Count=4; push 8'hE6 ->
//    o_Pready=1 with o_Perr=1, o_Overflow=1, o_Count stays 4, o_Data still 8'h01.
//  3 From full: pulse i_Done four times -> o_Data steps 01,02,03,04, then o_Busy=0,
//    o_Count=0; extra i_Done -> o_Count stays 0, no flag change.
//  4 Full FIFO, i_Enable(8'h0E) and i_Done same cycle -> accepted (o_Perr=0), o_Count=4,
//    8'h0E read last; 2 items, push+pop same cycle -> count 2, order preserved.
//  5 Wrap-around: 10 push/pop pairs, verify o_Data order vs. reference queue; i_ClrOvf
//    clears o_Overflow; set-wins when rejection coincides with clear.
//  6 Reset asserted with 3 words stored and i_Enable=1 -> next cycle o_Count=0, o_Busy=0,
//    o_Pready=0, o_Overflow=0; subsequent push 8'hA5 appears at o_Data normally.

Source files
------------

// File: rtl/txdatfifo_if.sv
// Bus-side write path and transmitter handshake of the Tx data FIFO.
interface txdatfifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             i_Enable;
  logic [WIDTH-1:0] i_Data;
  logic             i_Done;
  logic             i_ClrOvf;
  logic [WIDTH-1:0] o_Data;
  logic             o_Busy;
  logic             o_Pready;
  logic             o_Perr;
  logic             o_Full;
  logic             o_Low;
  logic [CW-1:0]    o_Count;
  logic             o_Overflow;

  modport master (
    output i_Enable, i_Data, i_Done, i_ClrOvf,
    input  o_Data, o_Busy, o_Pready, o_Perr, o_Full, o_Low, o_Count, o_Overflow
  );

  modport slave (
    input  i_Enable, i_Data, i_Done, i_ClrOvf,
    output o_Data, o_Busy, o_Pready, o_Perr, o_Full, o_Low, o_Count, o_Overflow
  );
endinterface

// File: rtl/txdatfifo.sv
// First-word-fall-through Tx data FIFO between bus writes and the USRT transmitter.
// Flags come from the registered occupancy counter only.
module txdatfifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int LOW_MARK = 1
) (
  input  logic        i_Pclk,
  input  logic        i_Reset,
  txdatfifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_CNT  = CW'(LOW_MARK);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             pready;
  logic             perr;
  logic             overflow;

  logic push_acc;
  logic push_rej;
  logic pop;

  // A full FIFO still takes a write when the head is popped in the same cycle.
  always_comb begin
    push_acc = 1'b0;
    push_rej = 1'b0;
    pop      = 1'b0;
    if (bus.i_Enable) begin
      if (count != FULL_CNT || bus.i_Done)
        push_acc = 1'b1;
      else
        push_rej = 1'b1;
    end
    if (bus.i_Done && count != '0)
      pop = 1'b1;
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pready   <= 1'b0;
      perr     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        mem[wptr] <= bus.i_Data;
        wptr      <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pready <= bus.i_Enable;
      perr   <= push_rej;
      // Set beats clear when both happen in one cycle.
      if (push_rej)
        overflow <= 1'b1;
      else if (bus.i_ClrOvf)
        overflow <= 1'b0;
    end
  end

  assign bus.o_Data     = mem[rptr];
  assign bus.o_Busy     = (count != '0);
  assign bus.o_Full     = (count == FULL_CNT);
  assign bus.o_Low      = (count <= LOW_CNT);
  assign bus.o_Count    = count;
  assign bus.o_Pready   = pready;
  assign bus.o_Perr     = perr;
  assign bus.o_Overflow = overflow;
endmodule

// File: tb/tb_txdatfifo.sv
// Directed bench for txdatfifo (WIDTH=8, DEPTH=4, LOW_MARK=1).
module tb_txdatfifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] q[$];

  txdatfifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  txdatfifo #(.WIDTH(8), .DEPTH(4), .LOW_MARK(1)) dut (
    .i_Pclk  (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic step(input logic en, input logic [7:0] d, input logic done,
                      input logic clr, input logic r);
    bus.i_Enable = en;
    bus.i_Data   = d;
    bus.i_Done   = done;
    bus.i_ClrOvf = clr;
    rst          = r;
    @(posedge clk);
    #1;
    bus.i_Enable = 1'b0;
    bus.i_Data   = 8'h00;
    bus.i_Done   = 1'b0;
    bus.i_ClrOvf = 1'b0;
    rst          = 1'b0;
  endtask

  initial begin
    bus.i_Enable = 1'b0;
    bus.i_Data   = 8'h00;
    bus.i_Done   = 1'b0;
    bus.i_ClrOvf = 1'b0;

    // reset
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(bus.o_Count), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_full", 32'(bus.o_Full), 32'd0);
    chk("rst_low", 32'(bus.o_Low), 32'd1);
    chk("rst_pready", 32'(bus.o_Pready), 32'd0);
    chk("rst_perr", 32'(bus.o_Perr), 32'd0);
    chk("rst_ovf", 32'(bus.o_Overflow), 32'd0);
    chk("rst_data", 32'(bus.o_Data), 32'h00);

    // single push into empty FIFO
    step(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
    chk("t1_pready", 32'(bus.o_Pready), 32'd1);
    chk("t1_perr", 32'(bus.o_Perr), 32'd0);
    chk("t1_busy", 32'(bus.o_Busy), 32'd1);
    chk("t1_data", 32'(bus.o_Data), 32'h53);
    chk("t1_count", 32'(bus.o_Count), 32'd1);
    chk("t1_low", 32'(bus.o_Low), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t1_pready_low", 32'(bus.o_Pready), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t1_pop_count", 32'(bus.o_Count), 32'd0);

    // fill, then reject one write
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("t2_fill_pready", 32'(bus.o_Pready), 32'd1);
      chk("t2_fill_count", 32'(bus.o_Count), 32'(i));
    end
    chk("t2_full", 32'(bus.o_Full), 32'd1);
    chk("t2_low_when_full", 32'(bus.o_Low), 32'd0);
    step(1'b1, 8'hE6, 1'b0, 1'b0, 1'b0);
    chk("t2_rej_pready", 32'(bus.o_Pready), 32'd1);
    chk("t2_rej_perr", 32'(bus.o_Perr), 32'd1);
    chk("t2_rej_ovf", 32'(bus.o_Overflow), 32'd1);
    chk("t2_rej_count", 32'(bus.o_Count), 32'd4);
    chk("t2_rej_data", 32'(bus.o_Data), 32'h01);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_perr_low", 32'(bus.o_Perr), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.o_Overflow), 32'd1);

    // drain, then underflow attempt
    for (int i = 1; i <= 4; i++) begin
      chk("t3_head", 32'(bus.o_Data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t3_busy", 32'(bus.o_Busy), 32'd0);
    chk("t3_count", 32'(bus.o_Count), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t3_uf_count", 32'(bus.o_Count), 32'd0);
    chk("t3_uf_busy", 32'(bus.o_Busy), 32'd0);
    chk("t3_uf_low", 32'(bus.o_Low), 32'd1);
    chk("t3_uf_full", 32'(bus.o_Full), 32'd0);

    // push+pop on a full FIFO is accepted
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);
    chk("t4_full_pp_pready", 32'(bus.o_Pready), 32'd1);
    chk("t4_full_pp_perr", 32'(bus.o_Perr), 32'd0);
    chk("t4_full_pp_count", 32'(bus.o_Count), 32'd4);
    chk("t4_full_pp_data", 32'(bus.o_Data), 32'h22);
    chk("t4_d1", 32'(bus.o_Data), 32'h22);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_d2", 32'(bus.o_Data), 32'h23);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_d3", 32'(bus.o_Data), 32'h24);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_d4", 32'(bus.o_Data), 32'h0E);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_empty", 32'(bus.o_Count), 32'd0);

    // two items, simultaneous push+pop keeps count and order
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    chk("t4_two_low", 32'(bus.o_Low), 32'd0);
    step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    chk("t4_pp_count", 32'(bus.o_Count), 32'd2);
    chk("t4_pp_head", 32'(bus.o_Data), 32'hBB);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_pp_tail", 32'(bus.o_Data), 32'hCC);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_pp_empty", 32'(bus.o_Count), 32'd0);

    // wrap-around against a reference queue
    q.push_back(8'h40);
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t5_wrap_head", 32'(bus.o_Data), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(8'(8'h41 + i));
      step(1'b1, 8'(8'h41 + i), 1'b1, 1'b0, 1'b0);
      chk("t5_wrap_count", 32'(bus.o_Count), 32'd1);
    end
    chk("t5_wrap_last", 32'(bus.o_Data), 32'(q[0]));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_wrap_empty", 32'(bus.o_Count), 32'd0);

    // overflow clear, then set-wins
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t5_clr", 32'(bus.o_Overflow), 32'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("t5_setwins_ovf", 32'(bus.o_Overflow), 32'd1);
    chk("t5_setwins_perr", 32'(bus.o_Perr), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_count", 32'(bus.o_Count), 32'd3);
    chk("t6_pre_ovf", 32'(bus.o_Overflow), 32'd1);

    // reset with data stored and a write pending
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 32'(bus.o_Count), 32'd0);
    chk("t6_busy", 32'(bus.o_Busy), 32'd0);
    chk("t6_pready", 32'(bus.o_Pready), 32'd0);
    chk("t6_ovf", 32'(bus.o_Overflow), 32'd0);
    chk("t6_data", 32'(bus.o_Data), 32'h00);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t6_push_data", 32'(bus.o_Data), 32'hA5);
    chk("t6_push_busy", 32'(bus.o_Busy), 32'd1);
    chk("t6_push_pready", 32'(bus.o_Pready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
